// File: rtl/muldiv_share_arbiter.sv
// muldiv_share_arbiter: round-robin sharing of one multiplier and one divider between two ALU lanes
// Ports: clk/rst (sync, active-high); flush kills the in-flight request;
//   req_* per-lane requests (lane i at slice i); grant one-hot accept pulse; stall per-lane scoreboard stall;
//   mul_start/div_start one-cycle unit starts; unit_* latched operands;
//   mul_/div_finish+result unit completions; resp_valid/resp_data/resp_rd result returned to a lane.
module muldiv_share_arbiter #(
  parameter int XLEN = 64,
  parameter int OPW  = 8,
  parameter int RAW  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_is_div,
  input  logic [2*OPW-1:0]  req_opcode,
  input  logic [2*XLEN-1:0] req_op1,
  input  logic [2*XLEN-1:0] req_op2,
  input  logic [2*RAW-1:0]  req_rd,
  output logic [1:0]        grant,
  output logic [1:0]        stall,
  output logic              mul_start,
  output logic              div_start,
  output logic [OPW-1:0]    unit_opcode,
  output logic [XLEN-1:0]   unit_op1,
  output logic [XLEN-1:0]   unit_op2,
  input  logic              mul_finish,
  input  logic [XLEN-1:0]   mul_result,
  input  logic              div_finish,
  input  logic [XLEN-1:0]   div_result,
  output logic [1:0]        resp_valid,
  output logic [XLEN-1:0]   resp_data,
  output logic [RAW-1:0]    resp_rd
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t r_state, w_next;
  logic r_rr, r_killed, r_is_div, r_lane;
  logic [1:0] r_served, w_elig;
  logic [OPW-1:0] r_opcode;
  logic [XLEN-1:0] r_op1, r_op2, r_resp_data, w_fin_data;
  logic [RAW-1:0] r_rd, r_resp_rd;
  logic w_win, w_go, w_fin, w_kill;
  // a lane that was answered stays ineligible until it drops req_valid
  assign w_elig = req_valid & ~r_served;
  assign w_win = &w_elig ? r_rr : w_elig[1];
  assign w_go = (r_state == IDLE) && |w_elig && !flush;
  // only the unit that was started may complete the operation
  assign w_fin = r_is_div ? div_finish : mul_finish;
  assign w_fin_data = r_is_div ? div_result : mul_result;
  // a flush coinciding with the finish also discards the result
  assign w_kill = r_killed || flush;
  assign stall = req_valid & ~r_served & ~resp_valid;
  assign unit_opcode = r_opcode;
  assign unit_op1 = r_op1;
  assign unit_op2 = r_op2;
  assign resp_data = r_resp_data;
  assign resp_rd = r_resp_rd;
  always_comb begin
    w_next = r_state;
    grant = 2'b00;
    mul_start = 1'b0;
    div_start = 1'b0;
    resp_valid = 2'b00;
    case (r_state)
      IDLE: begin
        w_next = w_go ? ISSUE : IDLE;
        grant = w_go ? (w_win ? 2'b10 : 2'b01) : 2'b00;
      end
      ISSUE: begin
        w_next = WAIT;
        mul_start = !r_is_div;
        div_start = r_is_div;
      end
      WAIT: w_next = !w_fin ? WAIT : w_kill ? IDLE : RESP;
      RESP: begin
        w_next = IDLE;
        resp_valid = flush ? 2'b00 : (r_lane ? 2'b10 : 2'b01);
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rr <= 1'b0;
      r_served <= 2'b00;
      r_killed <= 1'b0;
      r_is_div <= 1'b0;
      r_lane <= 1'b0;
      r_opcode <= '0;
      r_op1 <= '0;
      r_op2 <= '0;
      r_rd <= '0;
      r_resp_data <= '0;
      r_resp_rd <= '0;
    end else begin
      r_state <= w_next;
      r_killed <= (w_next == IDLE) ? 1'b0 : ((r_state == ISSUE || r_state == WAIT) && flush) ? 1'b1 : r_killed;
      r_served <= req_valid & (r_served | ((r_state == RESP) ? (r_lane ? 2'b10 : 2'b01) : 2'b00));
      if (r_state == RESP) r_rr <= ~r_lane;
      if (w_go) begin
        r_lane <= w_win;
        r_is_div <= req_is_div[w_win];
        r_opcode <= w_win ? req_opcode[2*OPW-1:OPW] : req_opcode[OPW-1:0];
        r_op1 <= w_win ? req_op1[2*XLEN-1:XLEN] : req_op1[XLEN-1:0];
        r_op2 <= w_win ? req_op2[2*XLEN-1:XLEN] : req_op2[XLEN-1:0];
        r_rd <= w_win ? req_rd[2*RAW-1:RAW] : req_rd[RAW-1:0];
      end
      if (r_state == WAIT && w_next == RESP) begin
        r_resp_data <= w_fin_data;
        r_resp_rd <= r_rd;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_share_arbiter.sv
// tb_muldiv_share_arbiter: randomized self-checking bench acting as both ALU lanes and both units
module tb_muldiv_share_arbiter;
  logic clk = 1'b0;
  logic rst, flush, mul_start, div_start, mul_finish, div_finish;
  logic [1:0] req_valid, req_is_div, grant, stall, resp_valid;
  logic [15:0] req_opcode;
  logic [127:0] req_op1, req_op2;
  logic [9:0] req_rd;
  logic [7:0] unit_opcode;
  logic [63:0] unit_op1, unit_op2, mul_result, div_result, resp_data;
  logic [4:0] resp_rd;
  int nchk = 0, nerr = 0;
  bit lv[2], ldiv[2], srv[2];
  logic [7:0] lopc[2];
  logic [63:0] lop1[2], lop2[2];
  logic [4:0] lrd[2];
  int rr = 0;
  always #5 clk = ~clk;
  muldiv_share_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_is_div(req_is_div),
    .req_opcode(req_opcode), .req_op1(req_op1), .req_op2(req_op2), .req_rd(req_rd),
    .grant(grant), .stall(stall), .mul_start(mul_start), .div_start(div_start),
    .unit_opcode(unit_opcode), .unit_op1(unit_op1), .unit_op2(unit_op2),
    .mul_finish(mul_finish), .mul_result(mul_result), .div_finish(div_finish), .div_result(div_result),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd)
  );
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic pulses(input bit f, input bit m, input bit d, input logic [63:0] mr, input logic [63:0] dr);
    flush = f;
    mul_finish = m;
    div_finish = d;
    mul_result = mr;
    div_result = dr;
  endtask
  task automatic drive();
    req_valid = {lv[1], lv[0]};
    req_is_div = {ldiv[1], ldiv[0]};
    req_opcode = {lopc[1], lopc[0]};
    req_op1 = {lop1[1], lop1[0]};
    req_op2 = {lop2[1], lop2[0]};
    req_rd = {lrd[1], lrd[0]};
  endtask
  task automatic new_req(input int i, input bit d, input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
    lv[i] = 1'b1;
    srv[i] = 1'b0;
    ldiv[i] = d;
    lop1[i] = a;
    lop2[i] = b;
    lrd[i] = rd;
    lopc[i] = 8'($urandom);
  endtask
  function automatic int winner();
    bit e0, e1;
    e0 = lv[0] && !srv[0];
    e1 = lv[1] && !srv[1];
    if (e0 && e1) return rr;
    return e0 ? 0 : e1 ? 1 : -1;
  endfunction
  function automatic logic [1:0] oh(input int l);
    return (l == 1) ? 2'b10 : 2'b01;
  endfunction
  function automatic logic [1:0] exp_stall(input logic [1:0] rm);
    return {lv[1] && !srv[1] && !rm[1], lv[0] && !srv[0] && !rm[0]};
  endfunction
  task automatic idle_cyc(input string tag);
    #1;
    chk(tag, grant, 2'b00);
    chk({tag, "_resp"}, resp_valid, 2'b00);
    step();
  endtask
  // entered at the start of an IDLE cycle with requests already driven; the
  // bench plays the selected unit, finishing fdly cycles after its start pulse
  task automatic transact(input int fdly, input bit kill, input bit spur);
    int ln, kc;
    logic [63:0] res;
    ln = winner();
    kc = (fdly > 1) ? 1 : 0;
    res = kill ? '1 : ldiv[ln] ? lop1[ln] / lop2[ln] : lop1[ln] * lop2[ln];
    #1;
    chk("grant", grant, oh(ln));
    chk("stall_grant", stall, exp_stall(2'b00));
    step();
    pulses(kill && kc == 0, spur, spur, 64'hBAD0, 64'hBAD1);
    #1;
    chk("start", {div_start, mul_start}, ldiv[ln] ? 2'b10 : 2'b01);
    chk("unit_opcode", unit_opcode, lopc[ln]);
    chk("unit_op1", unit_op1, lop1[ln]);
    chk("unit_op2", unit_op2, lop2[ln]);
    chk("stall_issue", stall, exp_stall(2'b00));
    for (int k = 1; k < fdly; k++) begin
      step();
      pulses(kill && kc == k, spur && k == 1 && ldiv[ln], spur && k == 1 && !ldiv[ln], 64'hBAD2, 64'hBAD3);
      #1;
      chk("wait_resp", resp_valid, 2'b00);
      chk("wait_start", {div_start, mul_start}, 2'b00);
      chk("stall_wait", stall, exp_stall(2'b00));
    end
    step();
    pulses(1'b0, !ldiv[ln] || spur, ldiv[ln] || spur, ldiv[ln] ? 64'hBAD4 : res, ldiv[ln] ? res : 64'hBAD5);
    #1;
    chk("fin_resp", resp_valid, 2'b00);
    chk("fin_op2", unit_op2, lop2[ln]);
    step();
    pulses(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    if (kill) begin
      lv[0] = 1'b0; lv[1] = 1'b0; srv[0] = 1'b0; srv[1] = 1'b0;
      drive();
      #1;
      chk("kill_resp", resp_valid, 2'b00);
      chk("kill_grant", grant, 2'b00);
    end else begin
      #1;
      chk("resp_valid", resp_valid, oh(ln));
      chk("resp_data", resp_data, res);
      chk("resp_rd", resp_rd, lrd[ln]);
      chk("stall_resp", stall, exp_stall(oh(ln)));
      srv[ln] = 1'b1;
      rr = 1 - ln;
    end
    step();
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 2; i++) begin
      lv[i] = 0; srv[i] = 0; ldiv[i] = 0; lopc[i] = 0; lop1[i] = 0; lop2[i] = 0; lrd[i] = 0;
    end
    drive();
    pulses(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("reset_outputs", {grant, stall, mul_start, div_start, unit_opcode, unit_op1, unit_op2, resp_valid, resp_data, resp_rd}, 0);
    step();
    // both lanes together after reset: lane 0 first, then lane 1, no re-grant while held
    new_req(0, 1'b0, 64'd11, 64'd13, 5'd2);
    new_req(1, 1'b1, 64'd100, 64'd7, 5'd3);
    drive();
    transact(2, 1'b0, 1'b0);
    transact(1, 1'b0, 1'b0);
    idle_cyc("no_regrant");
    lv[0] = 0; lv[1] = 0; srv[0] = 0; srv[1] = 0;
    drive();
    idle_cyc("dropped");
    // lane 0 alone: 7*6 finishing three cycles after the start
    new_req(0, 1'b0, 64'd7, 64'd6, 5'd5);
    drive();
    transact(3, 1'b0, 1'b0);
    // flushed divide: all-ones result is discarded and the pointer keeps pointing at lane 1
    lv[0] = 0; srv[0] = 0;
    new_req(1, 1'b1, 64'd999, 64'd3, 5'd9);
    drive();
    transact(3, 1'b1, 1'b0);
    new_req(0, 1'b0, 64'd5, 64'd5, 5'd1);
    new_req(1, 1'b1, 64'd81, 64'd9, 5'd4);
    drive();
    transact(3, 1'b0, 1'b1);
    transact(1, 1'b0, 1'b0);
    lv[0] = 0; lv[1] = 0; srv[0] = 0; srv[1] = 0;
    drive();
    idle_cyc("dropped2");
    // reset while waiting on the multiplier; the late finish must be ignored
    new_req(1, 1'b0, 64'd3, 64'd4, 5'd9);
    drive();
    #1;
    chk("rst_grant", grant, 2'b10);
    step();
    step();
    rst = 1'b1;
    lv[1] = 0; srv[1] = 0;
    drive();
    step();
    rst = 1'b0;
    pulses(1'b0, 1'b1, 1'b0, 64'd77, 64'h0);
    #1;
    chk("rst_outputs", {grant, stall, mul_start, div_start, unit_opcode, unit_op1, unit_op2, resp_valid, resp_data, resp_rd}, 0);
    step();
    pulses(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    rr = 0;
    #1;
    chk("rst_noresp", resp_valid, 2'b00);
    step();
    new_req(1, 1'b0, 64'd9, 64'd9, 5'd8);
    drive();
    transact(2, 1'b0, 1'b0);
    // randomized traffic
    for (int it = 0; it < 300; it++) begin
      for (int i = 0; i < 2; i++) begin
        if (!lv[i]) begin
          if ($urandom_range(0, 2) == 0)
            new_req(i, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom} | 64'h1, 5'($urandom_range(0, 31)));
        end else if (srv[i] && $urandom_range(0, 1) == 1) begin
          lv[i] = 1'b0;
          srv[i] = 1'b0;
        end
      end
      drive();
      if (winner() < 0) idle_cyc("idle_grant");
      else if ($urandom_range(0, 7) == 0) begin
        flush = 1'b1;
        #1;
        chk("flush_idle_grant", grant, 2'b00);
        step();
        flush = 1'b0;
      end else transact($urandom_range(1, 4), $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/muldiv_share_arbiter.md
Name: muldiv_share_arbiter

Overview:
Shares one multiplier and one divider between the two superscalar ALU lanes (lane 0 = ALUO, lane 1 = ALUT). Each lane posts a mul/div request and stalls until the result returns. The arbiter grants lanes round-robin and latches the winning request's operands. It pulses a start into the selected unit, waits for that unit's finish, and returns the result to the lane that requested it. It sits between the ALU lanes and the multiplier/divider, and provides each lane's scoreboard stall.

Parameters:
XLEN, 64, operand/result width
OPW, 8, inst_opcode width
RAW, 5, rd address width

Ports:
clk  in  1  clock
rst  in  1  reset
flush  in  1  pipeline kill; squashes pending request
req_valid  in  2  per-lane request, held high until served
req_is_div  in  2  per lane: 1 = divider, 0 = multiplier
req_opcode  in  2*OPW  per-lane opcode, lane i at [i*OPW +: OPW]
req_op1  in  2*XLEN  per-lane operand 1
req_op2  in  2*XLEN  per-lane operand 2
req_rd  in  2*RAW  per-lane destination register
grant  out  2  one-hot, 1-cycle pulse when a lane's request is accepted
stall  out  2  per-lane scoreboard stall
mul_start  out  1  1-cycle start to the multiplier
div_start  out  1  1-cycle start to the divider
unit_opcode  out  OPW  latched opcode
unit_op1  out  XLEN  latched operand 1
unit_op2  out  XLEN  latched operand 2
mul_finish  in  1  multiplier done pulse
mul_result  in  XLEN  multiplier result, valid with mul_finish
div_finish  in  1  divider done pulse
div_result  in  XLEN  divider result, valid with div_finish
resp_valid  out  2  one-hot, 1-cycle result pulse to a lane
resp_data  out  XLEN  result
resp_rd  out  RAW  destination register of the result

Behaviour:
- Reset: rst is synchronous, active-high. It forces state IDLE, rr_ptr=0, served=2'b00, killed=0, and clears all latches. All outputs read 0 in the cycle after rst is sampled. rst during ISSUE/WAIT abandons the operation, and a later unit finish is ignored because the state is IDLE.
- States: IDLE, ISSUE, WAIT, RESP.
- served[i]: set in RESP for the lane being answered; cleared whenever req_valid[i]=0. A lane is eligible only when req_valid[i] && !served[i].
- IDLE:
  - With flush=1, nothing is granted.
  - Otherwise, if both lanes are eligible, the winner is rr_ptr. If one lane is eligible, it wins.
  - On a win: grant[winner]=1 that cycle; latch opcode, op1, op2, rd, is_div and the lane id; next state ISSUE.
- ISSUE:
  - Drive div_start or mul_start =1 for exactly this cycle, selected by the latched is_div. unit_op*/unit_opcode are driven from the latches and stay stable until IDLE.
  - Next state WAIT.
- WAIT:
  - Only the finish of the selected unit is honoured; the other unit's finish is ignored.
  - On a finish: latch the result. If killed=1, go to IDLE and produce no response; otherwise go to RESP.
  - A finish arriving in the same cycle as ISSUE is ignored.
- RESP:
  - resp_valid[lane]=1, resp_data=latched result, resp_rd=latched rd, for one cycle.
  - served[lane]<=1; rr_ptr<=~lane; next state IDLE.
- Minimum latency: grant at cycle N, start at N+1, finish at N+2 or later, resp one cycle after the finish. Back-to-back: the next grant can occur in the cycle after RESP.
- flush:
  - In ISSUE or WAIT, flush sets killed. The start pulse still issues and the unit is allowed to complete; its result is discarded.
  - In RESP, flush suppresses resp_valid.
  - killed clears on entry to IDLE.
- stall[i] = req_valid[i] && !served[i] && !resp_valid[i]. It is combinational, so a lane stalls from the cycle it raises req_valid until its resp cycle.
- rr_ptr updates only in RESP; a killed operation does not flip it.
- Outside their active states: start pulses, grant and resp_valid are 0; resp_data and resp_rd hold their last value.

Test Plan:
- Lane 0 alone: req_is_div=0, op1=7, op2=6, rd=5; multiplier finishes 3 cycles after mul_start with 42 -> grant=01, mul_start the next cycle, resp_valid=01 with data=42 and rd=5 the cycle after the finish; stall[0] falls on the resp cycle.
- Both lanes request together after reset -> lane 0 is granted first. Lane 1 is granted in the cycle after lane 0's RESP, and its div_start follows. Responses go to the correct lanes in order.
- Lane 0 keeps req_valid high for one cycle after its resp -> no re-grant. A new request after req_valid drops for one cycle is granted.
- flush while in WAIT on a divide -> div_finish with 0xFFFF_FFFF_FFFF_FFFF produces no resp_valid. The state returns to IDLE and rr_ptr is unchanged.
- A mul_finish pulse during a divide WAIT is ignored; the response is taken only on div_finish.
- rst asserted in WAIT, then a finish pulse -> no response, all outputs 0, and the next request is granted normally.
